// File: rtl/word_check_pkg.sv
// word_check_pkg: shared types and helpers for the FSK test-word checker.
// Latency: n/a (package). Backpressure: n/a.
// Contents: checker state enum, word width constant shared with the
// transmitter-side walking-one generator, rotate and one-hot helpers.
package word_check_pkg;

   // Test-word width; the transmitter-side generator uses the same constant.
   localparam int WORD_W = 8;

   // Checker synchronisation states.
   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_e;

   // Rotate an 8-bit word left by one; 0x80 wraps to 0x01.
   function automatic logic [WORD_W-1:0] rotl8(input logic [WORD_W-1:0] x);
      return {x[WORD_W-2:0], x[WORD_W-1]};
   endfunction

   // True when exactly one bit is set (zero is not one-hot).
   function automatic logic is_onehot8(input logic [WORD_W-1:0] x);
      return (x != '0) && ((x & (x - {{(WORD_W-1){1'b0}}, 1'b1})) == '0);
   endfunction

endpackage

// File: rtl/word_check_popcount8.sv
// popcount8: counts the set bits of an 8-bit word.
// Latency: combinational. Backpressure: none.
// Ports: data_i (8-bit word), count_o (4-bit population count, 0..8).
module popcount8
   import word_check_pkg::*;
(
   input  logic [WORD_W-1:0] data_i,
   output logic [3:0]        count_o
);

   always_comb begin
      count_o = 4'd0;
      for (int i = 0; i < WORD_W; i++) begin
         count_o = count_o + {3'd0, data_i[i]};
      end
   end

endmodule

// File: rtl/word_check.sv
// word_check: receive-side checker for the walking-one FSK test-word stream.
// Latency: 1 clk_word cycle from a sampled word to every output.
// Backpressure: none; words are consumed on every valid strobe, valid=0 holds all state.
//
// Ports:
//   clk_word      word clock, all state updates on its rising edge
//   rst           asynchronous active-high reset
//   word/valid    received word and its strobe
//   locked        high while the checker is in LOCKED
//   err_pulse     one-cycle pulse per mismatched word checked while locked
//   word_count    saturating count of words checked while locked
//   err_count     saturating count of mismatched words checked while locked
//   bit_err_count saturating sum of bit errors over checked words
//
// LOCK_N and LOSS_N are legal in 1..15 (they are compared against 4-bit
// run counters). CNT_W must be at least 4 so one word's bit-error count fits.
module word_check
   import word_check_pkg::*;
#(
   parameter int LOCK_N = 4,
   parameter int LOSS_N = 3,
   parameter int CNT_W  = 16
) (
   input  logic              clk_word,
   input  logic              rst,
   input  logic [WORD_W-1:0] word,
   input  logic              valid,
   output logic              locked,
   output logic              err_pulse,
   output logic [CNT_W-1:0]  word_count,
   output logic [CNT_W-1:0]  err_count,
   output logic [CNT_W-1:0]  bit_err_count
);

   localparam logic [3:0]       LOCK_C  = LOCK_N[3:0];
   localparam logic [3:0]       LOSS_C  = LOSS_N[3:0];
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_e            state_q, state_d;
   logic [WORD_W-1:0] expected_q, expected_d;
   logic [3:0]        match_cnt_q, match_cnt_d;
   logic [3:0]        miss_cnt_q, miss_cnt_d;

   logic              locked_q, locked_d;
   logic              err_pulse_q, err_pulse_d;
   logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
   logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0]  bit_err_cnt_q, bit_err_cnt_d;

   // ------------------------------------------------------------------
   // Word classification
   // ------------------------------------------------------------------
   logic              is_match;
   logic              word_onehot;
   logic [WORD_W-1:0] diff_bits;
   logic [3:0]        diff_cnt;
   logic [3:0]        match_cnt_inc;
   logic [3:0]        miss_cnt_inc;
   logic [CNT_W:0]    bit_err_sum;

   assign is_match      = (word == expected_q);
   assign word_onehot   = is_onehot8(word);
   assign diff_bits     = word ^ expected_q;
   assign match_cnt_inc = match_cnt_q + 4'd1;
   assign miss_cnt_inc  = miss_cnt_q + 4'd1;

   popcount8 u_popcount (
      .data_i  (diff_bits),
      .count_o (diff_cnt)
   );

   // One extra bit catches the carry so the accumulator saturates instead of wrapping.
   assign bit_err_sum = {1'b0, bit_err_cnt_q} + {{(CNT_W-3){1'b0}}, diff_cnt};

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk_word or posedge rst) begin
      if (rst) begin
         state_q     <= HUNT;
         expected_q  <= '0;
         match_cnt_q <= 4'd0;
         miss_cnt_q  <= 4'd0;
      end else begin
         state_q     <= state_d;
         expected_q  <= expected_d;
         match_cnt_q <= match_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      expected_d  = expected_q;
      match_cnt_d = match_cnt_q;
      miss_cnt_d  = miss_cnt_q;

      if (valid) begin
         case (state_q)
            HUNT: begin
               if (word_onehot) begin
                  expected_d  = rotl8(word);
                  match_cnt_d = 4'd1;
                  miss_cnt_d  = 4'd0;
                  state_d     = (LOCK_C == 4'd1) ? LOCKED : VERIFY;
               end
            end

            VERIFY: begin
               if (is_match) begin
                  expected_d  = rotl8(word);
                  match_cnt_d = match_cnt_inc;
                  if (match_cnt_inc >= LOCK_C) begin
                     state_d    = LOCKED;
                     miss_cnt_d = 4'd0;
                  end
               end else if (word_onehot) begin
                  // A clean one-hot word that breaks the run starts a new run.
                  expected_d  = rotl8(word);
                  match_cnt_d = 4'd1;
                  if (LOCK_C == 4'd1) begin
                     state_d    = LOCKED;
                     miss_cnt_d = 4'd0;
                  end
               end else begin
                  match_cnt_d = 4'd0;
                  state_d     = HUNT;
               end
            end

            LOCKED: begin
               // Flywheel: the expected word advances on its own; received
               // words never reseed it while locked.
               expected_d = rotl8(expected_q);
               if (is_match) begin
                  miss_cnt_d = 4'd0;
               end else if (miss_cnt_inc >= LOSS_C) begin
                  miss_cnt_d  = 4'd0;
                  match_cnt_d = 4'd0;
                  state_d     = HUNT;
               end else begin
                  miss_cnt_d = miss_cnt_inc;
               end
            end

            default: begin
               state_d     = HUNT;
               match_cnt_d = 4'd0;
               miss_cnt_d  = 4'd0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // FSM: output / statistics logic (registered below)
   // ------------------------------------------------------------------
   always_comb begin
      locked_d      = (state_d == LOCKED);
      err_pulse_d   = 1'b0;
      word_cnt_d    = word_cnt_q;
      err_cnt_d     = err_cnt_q;
      bit_err_cnt_d = bit_err_cnt_q;

      // Only words sampled in LOCKED are counted, including the one that drops lock.
      if (valid && (state_q == LOCKED)) begin
         word_cnt_d = (word_cnt_q == CNT_MAX) ? CNT_MAX : word_cnt_q + CNT_ONE;
         if (!is_match) begin
            err_pulse_d   = 1'b1;
            err_cnt_d     = (err_cnt_q == CNT_MAX) ? CNT_MAX : err_cnt_q + CNT_ONE;
            bit_err_cnt_d = bit_err_sum[CNT_W] ? CNT_MAX : bit_err_sum[CNT_W-1:0];
         end
      end
   end

   always_ff @(posedge clk_word or posedge rst) begin
      if (rst) begin
         locked_q      <= 1'b0;
         err_pulse_q   <= 1'b0;
         word_cnt_q    <= '0;
         err_cnt_q     <= '0;
         bit_err_cnt_q <= '0;
      end else begin
         locked_q      <= locked_d;
         err_pulse_q   <= err_pulse_d;
         word_cnt_q    <= word_cnt_d;
         err_cnt_q     <= err_cnt_d;
         bit_err_cnt_q <= bit_err_cnt_d;
      end
   end

   assign locked        = locked_q;
   assign err_pulse     = err_pulse_q;
   assign word_count    = word_cnt_q;
   assign err_count     = err_cnt_q;
   assign bit_err_count = bit_err_cnt_q;

endmodule

// File: tb/tb_word_check.sv
// tb_word_check: self-checking bench for word_check.
// Latency: outputs sampled 1 time unit after each clk_word rising edge.
// Backpressure: n/a; the bench drives a word (or idle) every cycle.
module tb_word_check;

   logic        clk_word = 1'b0;
   logic        rst;
   logic [7:0]  word;
   logic        valid;

   logic        d_locked, d_err_pulse;
   logic [15:0] d_wc, d_ec, d_bc;
   logic        s_locked, s_err_pulse;
   logic [3:0]  s_wc, s_ec, s_bc;

   always #5 clk_word = ~clk_word;

   word_check u_dut (
      .clk_word      (clk_word),
      .rst           (rst),
      .word          (word),
      .valid         (valid),
      .locked        (d_locked),
      .err_pulse     (d_err_pulse),
      .word_count    (d_wc),
      .err_count     (d_ec),
      .bit_err_count (d_bc)
   );

   word_check #(.LOCK_N(4), .LOSS_N(3), .CNT_W(4)) u_sat (
      .clk_word      (clk_word),
      .rst           (rst),
      .word          (word),
      .valid         (valid),
      .locked        (s_locked),
      .err_pulse     (s_err_pulse),
      .word_count    (s_wc),
      .err_count     (s_ec),
      .bit_err_count (s_bc)
   );

   typedef struct {
      bit          sat;
      logic        lk;
      logic        ep;
      logic [15:0] wc;
      logic [15:0] ec;
      logic [15:0] bc;
   } exp_t;

   typedef struct {
      logic        v;
      logic [7:0]  w;
      logic        lk;
      logic        ep;
      logic [15:0] wc;
      logic [15:0] ec;
      logic [15:0] bc;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   function automatic exp_t mk(input bit sat, input logic lk, input logic ep,
                               input logic [15:0] wc, input logic [15:0] ec,
                               input logic [15:0] bc);
      exp_t e;
      e.sat = sat; e.lk = lk; e.ep = ep; e.wc = wc; e.ec = ec; e.bc = bc;
      return e;
   endfunction

   function automatic void add(input logic v, input logic [7:0] w, input logic lk,
                               input logic ep, input logic [15:0] wc,
                               input logic [15:0] ec, input logic [15:0] bc);
      vec_t t;
      t.v = v; t.w = w; t.lk = lk; t.ep = ep; t.wc = wc; t.ec = ec; t.bc = bc;
      tbl.push_back(t);
   endfunction

   task automatic compare(input string tag, input exp_t e);
      if (e.sat) begin
         chk({tag, ".locked"},    {15'd0, s_locked},    {15'd0, e.lk});
         chk({tag, ".err_pulse"}, {15'd0, s_err_pulse}, {15'd0, e.ep});
         chk({tag, ".word_count"},    {12'd0, s_wc}, e.wc);
         chk({tag, ".err_count"},     {12'd0, s_ec}, e.ec);
         chk({tag, ".bit_err_count"}, {12'd0, s_bc}, e.bc);
      end else begin
         chk({tag, ".locked"},    {15'd0, d_locked},    {15'd0, e.lk});
         chk({tag, ".err_pulse"}, {15'd0, d_err_pulse}, {15'd0, e.ep});
         chk({tag, ".word_count"},    d_wc, e.wc);
         chk({tag, ".err_count"},     d_ec, e.ec);
         chk({tag, ".bit_err_count"}, d_bc, e.bc);
      end
   endtask

   // Drive one cycle of stimulus, queue its expected result, and check the
   // result the DUT shows after the sampling edge.
   task automatic step(input string tag, input logic v, input logic [7:0] w, input exp_t e);
      exp_t got;
      @(negedge clk_word);
      valid = v;
      word  = w;
      sb.push_back(e);
      @(posedge clk_word);
      #1;
      if (sb.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s.scoreboard: got empty queue, expected one entry", tag);
      end else begin
         got = sb.pop_front();
         compare(tag, got);
      end
   endtask

   task automatic do_reset();
      @(negedge clk_word);
      rst   = 1'b1;
      valid = 1'b0;
      word  = 8'h00;
      repeat (2) @(posedge clk_word);
      @(negedge clk_word);
      rst = 1'b0;
   endtask

   initial begin
      logic [7:0] cur;
      rst   = 1'b1;
      valid = 1'b0;
      word  = 8'h00;

      // ---------------- vector table (default parameters) ----------------
      //   v  word   lk ep  wc  ec bc
      add(1, 8'h00, 0, 0,  0, 0, 0);   // zero is not one-hot: stay in HUNT
      add(1, 8'h03, 0, 0,  0, 0, 0);   // two bits set: stay in HUNT
      add(1, 8'h01, 0, 0,  0, 0, 0);   // seed
      add(1, 8'h02, 0, 0,  0, 0, 0);
      add(1, 8'h04, 0, 0,  0, 0, 0);
      add(1, 8'h08, 1, 0,  0, 0, 0);   // 4th correct word: lock, not counted
      add(1, 8'h10, 1, 0,  1, 0, 0);   // first counted word
      add(1, 8'h20, 1, 0,  2, 0, 0);
      add(1, 8'h40, 1, 0,  3, 0, 0);
      add(1, 8'h80, 1, 0,  4, 0, 0);
      add(1, 8'h01, 1, 0,  5, 0, 0);   // wrap 0x80 -> 0x01
      add(1, 8'h02, 1, 0,  6, 0, 0);
      add(1, 8'h04, 1, 0,  7, 0, 0);
      add(1, 8'h08, 1, 0,  8, 0, 0);
      add(1, 8'h10, 1, 0,  9, 0, 0);
      add(1, 8'h20, 1, 0, 10, 0, 0);
      add(1, 8'h40, 1, 0, 11, 0, 0);
      add(1, 8'h80, 1, 0, 12, 0, 0);
      add(1, 8'h01, 1, 0, 13, 0, 0);   // expected now 0x02
      add(1, 8'h03, 1, 1, 14, 1, 1);   // one bit wrong
      add(1, 8'h04, 1, 0, 15, 1, 1);   // flywheel accepts 0x04
      for (int i = 0; i < 5; i++)
         add(0, 8'hFF, 1, 0, 15, 1, 1); // idle cycles hold everything
      add(1, 8'h08, 1, 0, 16, 1, 1);   // expected 0x08 after idle
      add(1, 8'h00, 1, 1, 17, 2, 2);   // vs 0x10
      add(1, 8'h00, 1, 1, 18, 3, 3);   // vs 0x20
      add(1, 8'h00, 0, 1, 19, 4, 4);   // vs 0x40: 3rd miss drops lock, still counted
      add(1, 8'h01, 0, 0, 19, 4, 4);   // HUNT reseed -> VERIFY, expect 0x02
      add(1, 8'h02, 0, 0, 19, 4, 4);
      add(1, 8'h10, 0, 0, 19, 4, 4);   // one-hot mismatch reseeds run at 1
      add(1, 8'h20, 0, 0, 19, 4, 4);
      add(1, 8'h40, 0, 0, 19, 4, 4);
      add(1, 8'h80, 1, 0, 19, 4, 4);   // 4th of the new run locks
      add(1, 8'h01, 1, 0, 20, 4, 4);

      // ---------------- reset state ----------------
      #1;
      compare("rst_hold", mk(0, 0, 0, 0, 0, 0));
      compare("rst_hold_sat", mk(1, 0, 0, 0, 0, 0));
      do_reset();
      #1;
      compare("rst_rel", mk(0, 0, 0, 0, 0, 0));

      // ---------------- table-driven pass ----------------
      for (int i = 0; i < tbl.size(); i++) begin
         step($sformatf("vec%0d", i), tbl[i].v, tbl[i].w,
              mk(0, tbl[i].lk, tbl[i].ep, tbl[i].wc, tbl[i].ec, tbl[i].bc));
      end

      // ---------------- async reset mid-lock ----------------
      @(negedge clk_word);
      valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      compare("async_rst", mk(0, 0, 0, 0, 0, 0));
      @(negedge clk_word);
      rst = 1'b0;
      // First word after reset is HUNT input: 0x02 seeds a new run.
      step("post_rst0", 1, 8'h02, mk(0, 0, 0, 0, 0, 0));
      step("post_rst1", 1, 8'h04, mk(0, 0, 0, 0, 0, 0));
      step("post_rst2", 1, 8'h08, mk(0, 0, 0, 0, 0, 0));
      step("post_rst3", 1, 8'h10, mk(0, 1, 0, 0, 0, 0));

      // ---------------- VERIFY -> HUNT on a non-one-hot word ----------------
      do_reset();
      step("vh0", 1, 8'h01, mk(0, 0, 0, 0, 0, 0));
      step("vh1", 1, 8'h02, mk(0, 0, 0, 0, 0, 0));
      step("vh2", 1, 8'h05, mk(0, 0, 0, 0, 0, 0));   // back to HUNT
      step("vh3", 1, 8'h04, mk(0, 0, 0, 0, 0, 0));   // seed
      step("vh4", 1, 8'h08, mk(0, 0, 0, 0, 0, 0));
      step("vh5", 1, 8'h10, mk(0, 0, 0, 0, 0, 0));
      step("vh6", 1, 8'h20, mk(0, 1, 0, 0, 0, 0));

      // ---------------- counter saturation (CNT_W=4) ----------------
      do_reset();
      step("sat_l0", 1, 8'h01, mk(1, 0, 0, 0, 0, 0));
      step("sat_l1", 1, 8'h02, mk(1, 0, 0, 0, 0, 0));
      step("sat_l2", 1, 8'h04, mk(1, 0, 0, 0, 0, 0));
      step("sat_l3", 1, 8'h08, mk(1, 1, 0, 0, 0, 0));
      cur = 8'h10;
      for (int n = 1; n <= 20; n++) begin
         step($sformatf("sat_w%0d", n), 1, cur,
              mk(1, 1, 0, (n > 15) ? 16'd15 : 16'(n), 0, 0));
         cur = {cur[6:0], cur[7]};
      end
      // Every bit wrong: 8 bit errors per word, accumulator clamps at 0xF.
      step("sat_b0", 1, ~cur, mk(1, 1, 1, 15, 1, 8));
      cur = {cur[6:0], cur[7]};
      step("sat_b1", 1, ~cur, mk(1, 1, 1, 15, 2, 15));
      cur = {cur[6:0], cur[7]};
      step("sat_b2", 1, cur, mk(1, 1, 0, 15, 2, 15));

      // Async reset clears the saturated instance before the next edge.
      @(negedge clk_word);
      valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      compare("sat_async_rst", mk(1, 0, 0, 0, 0, 0));
      @(negedge clk_word);
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/word_check.md
# word_check

Receive-side checker for the FSK link's test-word stream. It sits after the demodulator and byte assembler, and consumes one 8-bit word per valid strobe on the word clock. It synchronises to the transmitter's walking-one sequence (0x01, 0x02, … 0x80, 0x01, …) and flywheels through errors. It reports lock status, per-word error pulses and saturating word, word-error and bit-error counts for link-quality measurement.

## Interface
Parameters:
- LOCK_N, 4: consecutive correct words (seed word included) required to declare lock; legal range 1..15.
- LOSS_N, 3: consecutive mismatched words while locked that drop lock; legal range 1..15.
- CNT_W, 16: width of all statistics counters.

Ports:
- clk_word  input  1  word clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- word  input  8  received word; sampled only when valid=1.
- valid  input  1  word strobe; 1 = word carries a new received word this cycle.
- locked  output  1  1 while the FSM is in LOCKED.
- err_pulse  output  1  one-cycle pulse for each mismatched word checked while locked.
- word_count  output  CNT_W  number of words checked while locked; saturating.
- err_count  output  CNT_W  number of mismatched words checked while locked; saturating.
- bit_err_count  output  CNT_W  sum of popcount(word ^ expected) over checked words; saturating.

## Operation
- One-hot test: word != 0 and (word & (word-1)) == 0.
- rotl(x) means rotate left by 1 (8-bit), so 0x80 -> 0x01.
- When valid=0, all state and counters hold; err_pulse=0. Only valid=1 cycles are "word events".
- States and transitions:
  - HUNT:
    - One-hot word w: expected <= rotl(w), match_cnt <= 1. Go to LOCKED if LOCK_N==1, else VERIFY.
    - Non-one-hot word: stay in HUNT.
    - No counting in this state.
  - VERIFY:
    - word == expected: match_cnt+1; when it reaches LOCK_N go to LOCKED.
    - Mismatch with a one-hot word: reseed as in HUNT, match_cnt <= 1.
    - Mismatch with a non-one-hot word: go to HUNT.
    - expected <= rotl(word) on a match or reseed.
    - No counting in this state.
  - LOCKED, every word event:
    - word_count+1.
    - expected <= rotl(expected). This is the flywheel; the received word is never used to reseed.
    - Match: miss_cnt <= 0.
    - Mismatch: err_count+1; bit_err_count += popcount(word ^ expected); err_pulse=1; miss_cnt+1.
    - When miss_cnt reaches LOSS_N, go to HUNT; that final word is still counted.
- Counters saturate at all ones and never wrap. bit_err_count saturates rather than overflowing on the add.
- Reset values: state HUNT, expected 0x00, match_cnt 0, miss_cnt 0. All outputs are 0 (locked, err_pulse, word_count, err_count, bit_err_count).

## Timing
- All outputs are registered. Effects of a word event are visible after the clk_word edge that samples it, so latency is 1 cycle.
- locked rises on the edge that samples the LOCK_N-th consecutive correct word. The first word counted in word_count is the next word event.
- locked falls on the edge that samples the LOSS_N-th consecutive mismatch. err_pulse and the counter updates for that word occur on the same edge.
- err_pulse is high for exactly one cycle per mismatched word. Back-to-back mismatches give back-to-back pulses.
- rst asserted at any time, including mid-lock, clears all state and outputs immediately and asynchronously. The first word event after rst deasserts is treated as HUNT input.

## Structure
- Shared package word_check_pkg holds:
  - the state enum {HUNT, VERIFY, LOCKED};
  - the rotl8 and is_onehot8 functions;
  - a WORD_W=8 constant, shared with the transmitter-side generator.
- One sub-module, popcount8: combinational, 8-bit in, 4-bit count out, feeding the bit-error accumulator.
- Statistics counters and saturation logic stay in word_check.

## Test plan
- Clean stream 0x01, 0x02, 0x04, 0x08, 0x10 with defaults: locked rises after 0x08; word_count=1 after 0x10; err_count=0.
- Wrap while locked (…0x40, 0x80, 0x01, 0x02): no err_pulse, locked stays 1, word_count increments by 4.
- Locked, expected 0x02, receive 0x03, then 0x04: one err_pulse; err_count=1, bit_err_count=1; locked stays 1 and 0x04 is accepted as correct.
- Locked, expected 0x10, receive 0x00 three times: locked falls on the third word; err_count=3, bit_err_count=3; the next 0x01 puts the FSM in VERIFY with expected 0x02.
- valid=0 for 5 cycles with word=0xFF, mid-lock: no state, counter or err_pulse change.
- Force word_count to its maximum (CNT_W=4, 20 locked words): holds at 0xF. Assert rst mid-lock: all outputs 0 before the next clk_word edge.
